// File: rtl/csa_operand_collector.sv
// Operand collector feeding the 3-input carry-save adder: packs a WIDTH-bit
// operand stream into zero-padded triples held stable until the adder accepts them.
module csa_operand_collector #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] trip_a,
    output logic [WIDTH-1:0] trip_b,
    output logic [WIDTH-1:0] trip_c,
    output logic [1:0]       trip_cnt,
    output logic             trip_last,
    output logic [IDX_W-1:0] trip_idx,
    output logic             trip_valid,
    input  logic             trip_ready
);

    logic [1:0]       slot;
    logic [WIDTH-1:0] stg_a_p0;
    logic [WIDTH-1:0] stg_b_p0;
    logic             accept;
    logic             emit;
    logic             close;

    assign in_ready = !trip_valid | trip_ready;
    assign accept   = in_valid & in_ready;
    assign emit     = trip_valid & trip_ready;
    assign close    = in_last | (slot == 2'd2);

    // Stage p0: staging registers for the first two operands of a partial triple
    always_ff @(posedge clk) begin
        if (accept && slot == 2'd0) stg_a_p0 <= in_data;
        if (accept && slot == 2'd1) stg_b_p0 <= in_data;
    end

    // Fill-slot tracking; a partial triple is dropped by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= 2'd0;
        end else if (accept) begin
            slot <= close ? 2'd0 : slot + 2'd1;
        end
    end

    // Stage p1: presented triple, written only when a triple closes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trip_a     <= '0;
            trip_b     <= '0;
            trip_c     <= '0;
            trip_cnt   <= 2'd0;
            trip_last  <= 1'b0;
            trip_idx   <= '0;
            trip_valid <= 1'b0;
        end else begin
            if (emit) begin
                trip_valid <= 1'b0;
                trip_idx   <= trip_last ? '0 : trip_idx + IDX_W'(1);
            end
            // A close on the same edge as an emit replaces the outgoing triple
            if (accept && close) begin
                trip_valid <= 1'b1;
                trip_a     <= (slot == 2'd0) ? in_data : stg_a_p0;
                trip_b     <= (slot == 2'd1) ? in_data : ((slot == 2'd2) ? stg_b_p0 : '0);
                trip_c     <= (slot == 2'd2) ? in_data : '0;
                trip_cnt   <= slot + 2'd1;
                trip_last  <= in_last;
            end
        end
    end

endmodule

// File: tb/tb_csa_operand_collector.sv
// Directed bench for csa_operand_collector: triple grouping, padding, stalls,
// async reset and sequence-index wrap.
module tb_csa_operand_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] trip_a;
    logic [31:0] trip_b;
    logic [31:0] trip_c;
    logic [1:0]  trip_cnt;
    logic        trip_last;
    logic [7:0]  trip_idx;
    logic        trip_valid;
    logic        trip_ready;

    int tests = 0;
    int fails = 0;

    csa_operand_collector #(.WIDTH(32), .IDX_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .trip_a(trip_a), .trip_b(trip_b), .trip_c(trip_c), .trip_cnt(trip_cnt),
        .trip_last(trip_last), .trip_idx(trip_idx), .trip_valid(trip_valid),
        .trip_ready(trip_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
        $fatal(1);
    end

    // Offer one operand for exactly one cycle; caller guarantees in_ready.
    task automatic put(input logic [31:0] d, input logic l);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        trip_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (trip_valid !== 1'b0 || trip_a !== 32'd0 || trip_b !== 32'd0 || trip_c !== 32'd0) begin
            fails++;
            $display("FAIL reset_data: valid=%b a=%h b=%h c=%h required 0/0/0/0", trip_valid, trip_a, trip_b, trip_c);
        end
        tests++;
        if (trip_cnt !== 2'd0 || trip_last !== 1'b0 || trip_idx !== 8'd0) begin
            fails++;
            $display("FAIL reset_ctrl: cnt=%0d last=%b idx=%0d required 0/0/0", trip_cnt, trip_last, trip_idx);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        do_reset();
        trip_ready = 1'b1;
        put(32'd5, 1'b0);
        put(32'd7, 1'b0);
        put(32'd9, 1'b0);
        tests++;
        if (trip_valid !== 1'b1 || trip_a !== 32'd5 || trip_b !== 32'd7 || trip_c !== 32'd9) begin
            fails++;
            $display("FAIL basic_triple: valid=%b a=%0d b=%0d c=%0d required 1/5/7/9", trip_valid, trip_a, trip_b, trip_c);
        end
        tests++;
        if (trip_cnt !== 2'd3 || trip_idx !== 8'd0 || trip_last !== 1'b0) begin
            fails++;
            $display("FAIL basic_ctrl: cnt=%0d idx=%0d last=%b required 3/0/0", trip_cnt, trip_idx, trip_last);
        end
        @(posedge clk);
        #1;
        tests++;
        if (trip_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_one_cycle: valid=%b required 0", trip_valid);
        end
    endtask

    task automatic test_back_to_back();
        int bubbles = 0;
        do_reset();
        trip_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if (in_ready !== 1'b1) bubbles++;
            put(32'(i), 1'b0);
            if (i == 3) begin
                tests++;
                if (trip_valid !== 1'b1 || trip_a !== 32'd1 || trip_b !== 32'd2 || trip_c !== 32'd3 || trip_idx !== 8'd0) begin
                    fails++;
                    $display("FAIL b2b_first: v=%b a=%0d b=%0d c=%0d idx=%0d required 1/1/2/3/0", trip_valid, trip_a, trip_b, trip_c, trip_idx);
                end
            end
        end
        tests++;
        if (trip_valid !== 1'b1 || trip_a !== 32'd4 || trip_b !== 32'd5 || trip_c !== 32'd6 || trip_idx !== 8'd1) begin
            fails++;
            $display("FAIL b2b_second: v=%b a=%0d b=%0d c=%0d idx=%0d required 1/4/5/6/1", trip_valid, trip_a, trip_b, trip_c, trip_idx);
        end
        tests++;
        if (bubbles != 0) begin
            fails++;
            $display("FAIL b2b_in_ready: %0d cycles with in_ready low, required 0", bubbles);
        end
    endtask

    task automatic test_tail_pad();
        do_reset();
        trip_ready = 1'b1;
        put(32'hFFFF_FFFF, 1'b1);
        tests++;
        if (trip_valid !== 1'b1 || trip_a !== 32'hFFFF_FFFF || trip_b !== 32'd0 || trip_c !== 32'd0) begin
            fails++;
            $display("FAIL tail_data: v=%b a=%h b=%h c=%h required 1/ffffffff/0/0", trip_valid, trip_a, trip_b, trip_c);
        end
        tests++;
        if (trip_cnt !== 2'd1 || trip_last !== 1'b1 || trip_idx !== 8'd0) begin
            fails++;
            $display("FAIL tail_ctrl: cnt=%0d last=%b idx=%0d required 1/1/0", trip_cnt, trip_last, trip_idx);
        end
        put(32'd1, 1'b0);
        put(32'd2, 1'b0);
        put(32'd3, 1'b0);
        tests++;
        if (trip_valid !== 1'b1 || trip_idx !== 8'd0 || trip_last !== 1'b0 || trip_a !== 32'd1) begin
            fails++;
            $display("FAIL tail_next_stream: v=%b idx=%0d last=%b a=%0d required 1/0/0/1", trip_valid, trip_idx, trip_last, trip_a);
        end
    endtask

    task automatic test_emit_close();
        do_reset();
        trip_ready = 1'b1;
        put(32'd1, 1'b0);
        put(32'd2, 1'b0);
        put(32'd3, 1'b0);
        put(32'd4, 1'b1);
        tests++;
        if (trip_valid !== 1'b1 || trip_a !== 32'd4 || trip_b !== 32'd0 || trip_c !== 32'd0 || trip_cnt !== 2'd1) begin
            fails++;
            $display("FAIL emit_close_data: v=%b a=%0d b=%0d c=%0d cnt=%0d required 1/4/0/0/1", trip_valid, trip_a, trip_b, trip_c, trip_cnt);
        end
        tests++;
        if (trip_idx !== 8'd1 || trip_last !== 1'b1) begin
            fails++;
            $display("FAIL emit_close_idx: idx=%0d last=%b required 1/1", trip_idx, trip_last);
        end
        put(32'd8, 1'b0);
        put(32'd9, 1'b1);
        tests++;
        if (trip_valid !== 1'b1 || trip_a !== 32'd8 || trip_b !== 32'd9 || trip_c !== 32'd0 || trip_cnt !== 2'd2 || trip_idx !== 8'd0) begin
            fails++;
            $display("FAIL pad_two: v=%b a=%0d b=%0d c=%0d cnt=%0d idx=%0d required 1/8/9/0/2/0", trip_valid, trip_a, trip_b, trip_c, trip_cnt, trip_idx);
        end
        put(32'd11, 1'b0);
        put(32'd12, 1'b0);
        put(32'd13, 1'b1);
        tests++;
        if (trip_a !== 32'd11 || trip_b !== 32'd12 || trip_c !== 32'd13 || trip_cnt !== 2'd3 || trip_last !== 1'b1 || trip_idx !== 8'd0) begin
            fails++;
            $display("FAIL last_full: a=%0d b=%0d c=%0d cnt=%0d last=%b idx=%0d required 11/12/13/3/1/0", trip_a, trip_b, trip_c, trip_cnt, trip_last, trip_idx);
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        do_reset();
        trip_ready = 1'b0;
        put(32'd1, 1'b0);
        put(32'd2, 1'b0);
        put(32'd3, 1'b0);
        in_data  = 32'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (in_ready !== 1'b0 || trip_valid !== 1'b1 || trip_a !== 32'd1 || trip_b !== 32'd2 || trip_c !== 32'd3) bad++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stall_hold: %0d stalled cycles disturbed, required 0", bad);
        end
        trip_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests++;
        if (trip_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_release: valid=%b required 0", trip_valid);
        end
        put(32'd5, 1'b0);
        put(32'd6, 1'b0);
        tests++;
        if (trip_valid !== 1'b1 || trip_a !== 32'd4 || trip_b !== 32'd5 || trip_c !== 32'd6 || trip_idx !== 8'd1) begin
            fails++;
            $display("FAIL stall_operand_once: v=%b a=%0d b=%0d c=%0d idx=%0d required 1/4/5/6/1", trip_valid, trip_a, trip_b, trip_c, trip_idx);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        trip_ready = 1'b1;
        put(32'd1, 1'b0);
        put(32'd2, 1'b0);
        put(32'd3, 1'b0);
        put(32'd10, 1'b0);
        put(32'd20, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (trip_valid !== 1'b0 || trip_a !== 32'd0 || trip_b !== 32'd0 || trip_c !== 32'd0 || trip_idx !== 8'd0) begin
            fails++;
            $display("FAIL async_reset: v=%b a=%0d b=%0d c=%0d idx=%0d required all 0", trip_valid, trip_a, trip_b, trip_c, trip_idx);
        end
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        put(32'd30, 1'b0);
        put(32'd40, 1'b0);
        put(32'd50, 1'b0);
        tests++;
        if (trip_valid !== 1'b1 || trip_a !== 32'd30 || trip_b !== 32'd40 || trip_c !== 32'd50 || trip_idx !== 8'd0) begin
            fails++;
            $display("FAIL async_reset_discard: v=%b a=%0d b=%0d c=%0d idx=%0d required 1/30/40/50/0", trip_valid, trip_a, trip_b, trip_c, trip_idx);
        end
    endtask

    task automatic test_idx_wrap();
        logic [7:0] exp_idx;
        do_reset();
        trip_ready = 1'b1;
        for (int k = 0; k < 257; k++) begin
            put(32'(3 * k + 1), 1'b0);
            put(32'(3 * k + 2), 1'b0);
            put(32'(3 * k + 3), 1'b0);
            exp_idx = 8'(k);
            tests++;
            if (trip_valid !== 1'b1 || trip_idx !== exp_idx || trip_c !== 32'(3 * k + 3)) begin
                fails++;
                $display("FAIL idx_wrap_%0d: v=%b idx=%0d c=%0d required 1/%0d/%0d", k, trip_valid, trip_idx, trip_c, exp_idx, 3 * k + 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_tail_pad();
        test_emit_close();
        test_stall();
        test_async_reset();
        test_idx_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
